// File: rtl/stack_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
// Op encoding is {push,pop}; count width derives from depth.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stack_lifo_if.sv
// Request/status bundle between the stack and its user.
// STACK_HWM_EN adds the max_count high-water mark.
interface stack_lifo_if
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] top;
  logic [CNT_W-1:0]      count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  underflow;
  logic                  error;
`ifdef STACK_HWM_EN
  logic [CNT_W-1:0]      max_count;
`endif

`ifdef STACK_HWM_EN
  modport master (
    output push, pop, data_in,
    input  data_out, out_valid, top, count,
    input  empty, full, overflow, underflow,
    input  error, max_count
  );
  modport slave (
    input  push, pop, data_in,
    output data_out, out_valid, top, count,
    output empty, full, overflow, underflow,
    output error, max_count
  );
`else
  modport master (
    output push, pop, data_in,
    input  data_out, out_valid, top, count,
    input  empty, full, overflow, underflow,
    input  error
  );
  modport slave (
    input  push, pop, data_in,
    output data_out, out_valid, top, count,
    output empty, full, overflow, underflow,
    output error
  );
`endif

endinterface

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port, one async read port.
// No reset; contents are only meaningful below the stack pointer.
module stack_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_lifo.sv
// Parametrised LIFO stack with replace, flags and status.
// Optional macro STACK_HWM_EN adds the max_count high-water mark.
module stack_lifo
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input logic        clk,
  input logic        reset_n,
  stack_lifo_if.slave bus
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int AW    = CNT_W - 1;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEPTH);

  typedef logic [AW-1:0] idx_t;

  op_e                   op;
  logic [CNT_W-1:0]      sp, sp_nx;
  logic [DATA_WIDTH-1:0] dout_q, dout_nx;
  logic                  ov_q, ov_nx;
  logic                  ovf_q, ovf_nx;
  logic                  udf_q, udf_nx;
  logic                  err_q;
  logic                  empty, full;
  logic                  we;
  idx_t                  waddr, top_idx;
  logic [DATA_WIDTH-1:0] rdata;

  assign op      = op_e'({bus.push, bus.pop});
  assign empty   = (sp == '0);
  assign full    = (sp == LIMIT);
  assign top_idx = idx_t'(sp - ONE);

  stack_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(bus.data_in),
    .raddr(top_idx),
    .rdata(rdata)
  );

  // Decode the sampled request into next pointer, data and flags.
  always_comb begin
    sp_nx   = sp;
    dout_nx = dout_q;
    ov_nx   = 1'b0;
    ovf_nx  = 1'b0;
    udf_nx  = 1'b0;
    we      = 1'b0;
    waddr   = sp[AW-1:0];
    unique case (op)
      OP_PUSH: begin
        if (!full) begin
          we    = 1'b1;
          sp_nx = sp + ONE;
        end else begin
          ovf_nx = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty) begin
          dout_nx = rdata;
          sp_nx   = sp - ONE;
          ov_nx   = 1'b1;
        end else begin
          udf_nx = 1'b1;
        end
      end
      OP_REPL: begin
        ov_nx = 1'b1;
        if (!empty) begin
          dout_nx = rdata;
          we      = 1'b1;
          waddr   = top_idx;
        end else begin
          dout_nx = bus.data_in;
        end
      end
      default: ;
    endcase
  end

  // Pointer, output data and one-cycle / sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp     <= '0;
      dout_q <= '0;
      ov_q   <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sp     <= sp_nx;
      dout_q <= dout_nx;
      ov_q   <= ov_nx;
      ovf_q  <= ovf_nx;
      udf_q  <= udf_nx;
      err_q  <= err_q | ovf_nx | udf_nx;
    end
  end

`ifdef STACK_HWM_EN
  logic [CNT_W-1:0] hwm_q;

  // Track the highest occupancy seen since reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hwm_q <= '0;
    else if (sp_nx > hwm_q) hwm_q <= sp_nx;
  end

  assign bus.max_count = hwm_q;
`endif

  assign bus.data_out  = dout_q;
  assign bus.out_valid = ov_q;
  assign bus.top       = empty ? '0 : rdata;
  assign bus.count     = sp;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
  assign bus.error     = err_q;

endmodule

// File: tb/tb_stack_lifo.sv
// Directed vector bench for stack_lifo (8 x 16 defaults).
// Covers push/pop order, replace, pass-through, flags and reset.
module tb_stack_lifo;
  import stack_pkg::*;

  localparam int DW = 8;
  localparam int DP = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  stack_lifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  stack_lifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [4:0] cnt;
    logic [7:0] top;
    logic       emp;
    logic       ful;
    logic       ov;
    logic [7:0] dout;
    logic       ovf;
    logic       udf;
    logic       err;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic q, input logic [7:0] d);
    bus.push    = p;
    bus.pop     = q;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b0, 8'h11, 5'd1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 8'h22, 5'd2, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 8'h33, 5'd3, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 8'h00, 5'd2, 8'h22, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 8'h00, 5'd1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 8'h00, 5'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 8'h00, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 8'h5A, 5'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 8'h11, 5'd1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 8'h22, 5'd2, 8'h22, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b1, 8'h99, 5'd2, 8'h99, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 8'h00, 5'd1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b1, 8'h00, 5'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b0, 1'b1, 8'h00, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b1};
    vt[14] = '{1'b0, 1'b0, 8'h00, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1};

    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_dout", 32'(bus.data_out), 32'd0);
    chk("rst_ov", 32'(bus.out_valid), 32'd0);
    chk("rst_top", 32'(bus.top), 32'd0);
    chk("rst_err", 32'(bus.error), 32'd0);

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].push, vt[i].pop, vt[i].din);
      chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(vt[i].cnt));
      chk($sformatf("v%0d_top", i), 32'(bus.top), 32'(vt[i].top));
      chk($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(vt[i].emp));
      chk($sformatf("v%0d_full", i), 32'(bus.full), 32'(vt[i].ful));
      chk($sformatf("v%0d_oval", i), 32'(bus.out_valid), 32'(vt[i].ov));
      chk($sformatf("v%0d_dout", i), 32'(bus.data_out), 32'(vt[i].dout));
      chk($sformatf("v%0d_ovf", i), 32'(bus.overflow), 32'(vt[i].ovf));
      chk($sformatf("v%0d_udf", i), 32'(bus.underflow), 32'(vt[i].udf));
      chk($sformatf("v%0d_err", i), 32'(bus.error), 32'(vt[i].err));
    end

    // Fill to full, then overflow and replace-when-full.
    do_reset();
    for (int i = 0; i < DP; i++) begin
      drive(1'b1, 1'b0, 8'(i));
    end
    chk("fill_count", 32'(bus.count), 32'd16);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_top", 32'(bus.top), 32'h0F);
    chk("fill_err", 32'(bus.error), 32'd0);
    drive(1'b1, 1'b0, 8'hAA);
    chk("ovf_pulse", 32'(bus.overflow), 32'd1);
    chk("ovf_err", 32'(bus.error), 32'd1);
    chk("ovf_top", 32'(bus.top), 32'h0F);
    chk("ovf_count", 32'(bus.count), 32'd16);
    drive(1'b0, 1'b0, 8'h00);
    chk("ovf_clear", 32'(bus.overflow), 32'd0);
    chk("ovf_sticky", 32'(bus.error), 32'd1);
    drive(1'b1, 1'b1, 8'hC3);
    chk("replf_dout", 32'(bus.data_out), 32'h0F);
    chk("replf_oval", 32'(bus.out_valid), 32'd1);
    chk("replf_ovf", 32'(bus.overflow), 32'd0);
    chk("replf_top", 32'(bus.top), 32'hC3);
    chk("replf_count", 32'(bus.count), 32'd16);
    drive(1'b0, 1'b1, 8'h00);
    chk("replf_pop", 32'(bus.data_out), 32'hC3);
    chk("replf_top2", 32'(bus.top), 32'h0E);

    // Async reset between edges clears state immediately.
    do_reset();
    drive(1'b1, 1'b1, 8'h77);
    chk("pt_dout", 32'(bus.data_out), 32'h77);
    drive(1'b0, 1'b1, 8'h00);
    chk("udf_dout_hold", 32'(bus.data_out), 32'h77);
    chk("udf_oval", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'(8'h40 + i));
    end
    bus.push = 1'b0;
    chk("pre_rst_count", 32'(bus.count), 32'd5);
    chk("pre_rst_err", 32'(bus.error), 32'd1);
`ifdef STACK_HWM_EN
    chk("pre_rst_hwm", 32'(bus.max_count), 32'd5);
`endif
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_err", 32'(bus.error), 32'd0);
    chk("arst_empty", 32'(bus.empty), 32'd1);
    chk("arst_dout", 32'(bus.data_out), 32'd0);
`ifdef STACK_HWM_EN
    chk("arst_hwm", 32'(bus.max_count), 32'd0);
`endif
    #1;
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    chk("post_rst_count", 32'(bus.count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
